// File: rtl/i2s_transmitter.sv
// I2S serial transmitter: free-running bit clock, one sample pair per frame,
// left slot on lrck=0, MSB one bck after the word-select edge.
module i2s_transmitter #(
    parameter int          SAMPLE_BITS = 24,
    parameter int          SLOT_BITS   = 32,
    parameter int          BCK_HALF    = 2,
    parameter logic [15:0] UFC_RESET   = 16'h0000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [2*SAMPLE_BITS-1:0] samples_data,
    input  logic                     samples_valid,
    output logic                     samples_ready,
    output logic                     bck,
    output logic                     lrck,
    output logic                     sdata,
    output logic                     underflow,
    output logic [15:0]              underflow_count
);

    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int DIV_W      = (BCK_HALF > 1) ? $clog2(BCK_HALF) : 1;
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_HALF - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] SLOT_W   = BIT_W'(SLOT_BITS);
    localparam logic [BIT_W-1:0] SAMP_W   = BIT_W'(SAMPLE_BITS);

    logic [DIV_W-1:0]         div_cnt_r;
    logic [BIT_W-1:0]         bit_cnt_r;
    logic                     bck_r;
    logic                     lrck_r;
    logic                     sdata_r;
    logic                     ready_r;
    logic                     underflow_r;
    logic [15:0]              ufc_r;
    logic [2*SAMPLE_BITS-1:0] frame_r;

    logic                     tick_s;
    logic                     fall_s;
    logic                     boundary_s;
    logic [BIT_W-1:0]         next_bit_s;
    logic                     right_s;
    logic [BIT_W-1:0]         slot_pos_s;
    logic [SAMPLE_BITS-1:0]   chan_s;
    logic [SAMPLE_BITS-1:0]   shifted_s;
    int                       shift_s;
    logic                     sdata_next_s;

    // Divider tick, fall-event detection and the serial bit for the next bck period.
    always_comb begin
        tick_s       = (div_cnt_r == DIV_LAST);
        fall_s       = tick_s && bck_r;
        boundary_s   = fall_s && (bit_cnt_r == BIT_LAST);
        next_bit_s   = '0;
        right_s      = 1'b0;
        slot_pos_s   = '0;
        chan_s       = '0;
        shifted_s    = '0;
        shift_s      = 0;
        sdata_next_s = 1'b0;
        if (bit_cnt_r == BIT_LAST) begin
            next_bit_s = '0;
        end else begin
            next_bit_s = bit_cnt_r + BIT_W'(1);
        end
        right_s = (next_bit_s >= SLOT_W);
        if (right_s) begin
            slot_pos_s = next_bit_s - SLOT_W;
            chan_s     = frame_r[SAMPLE_BITS-1:0];
        end else begin
            slot_pos_s = next_bit_s;
            chan_s     = frame_r[2*SAMPLE_BITS-1:SAMPLE_BITS];
        end
        // Slot position 0 is the one-bck I2S delay; positions past the sample are padding.
        if ((slot_pos_s >= BIT_W'(1)) && (slot_pos_s <= SAMP_W)) begin
            shift_s      = SAMPLE_BITS - int'(slot_pos_s);
            shifted_s    = chan_s >> shift_s;
            sdata_next_s = shifted_s[0];
        end else begin
            sdata_next_s = 1'b0;
        end
    end

    // Bit clock, frame sequencing, sample handshake and underflow accounting.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_cnt_r   <= '0;
            bit_cnt_r   <= BIT_LAST;
            bck_r       <= 1'b0;
            lrck_r      <= 1'b1;
            sdata_r     <= 1'b0;
            ready_r     <= 1'b0;
            underflow_r <= 1'b0;
            ufc_r       <= UFC_RESET;
            frame_r     <= '0;
        end else begin
            ready_r     <= 1'b0;
            underflow_r <= 1'b0;
            if (tick_s) begin
                div_cnt_r <= '0;
                bck_r     <= ~bck_r;
            end else begin
                div_cnt_r <= div_cnt_r + DIV_W'(1);
            end
            if (fall_s) begin
                bit_cnt_r <= next_bit_s;
                lrck_r    <= right_s;
                sdata_r   <= sdata_next_s;
            end
            // The frame register is cleared at every boundary so a starved or
            // disabled frame shifts out zeros; the ready cycle refills it.
            if (boundary_s) begin
                frame_r <= '0;
                ready_r <= enable;
            end else if (ready_r && samples_valid) begin
                frame_r <= samples_data;
            end
            if (ready_r && !samples_valid) begin
                underflow_r <= 1'b1;
                if (ufc_r != 16'hFFFF) begin
                    ufc_r <= ufc_r + 16'd1;
                end
            end
        end
    end

    assign samples_ready   = ready_r;
    assign bck             = bck_r;
    assign lrck            = lrck_r;
    assign sdata           = sdata_r;
    assign underflow       = underflow_r;
    assign underflow_count = ufc_r;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Testbench for i2s_transmitter: an I2S receiver model decodes the serial stream
// and the decoded words are compared against the pairs the bench handed over.
module tb_i2s_transmitter;

    localparam int SB        = 24;
    localparam int SLOT      = 32;
    localparam int BH        = 2;
    localparam int FRAME_CLK = 2 * SLOT * 2 * BH;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic [2*SB-1:0] samples_data;
    logic          samples_valid;
    logic          samples_ready;
    logic          bck, lrck, sdata, underflow;
    logic [15:0]   underflow_count;

    logic          sat_ready, sat_bck, sat_lrck, sat_sdata, sat_underflow;
    logic [15:0]   sat_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0, ready_cnt = 0, uf_cnt = 0, sat_uf_cnt = 0, fall_cnt = 0;

    logic [SB-1:0]   dec_l[$];
    logic [SB-1:0]   dec_r[$];
    logic [2*SB-1:0] exp_q[$];

    always #5 clk = ~clk;

    i2s_transmitter #(.SAMPLE_BITS(SB), .SLOT_BITS(SLOT), .BCK_HALF(BH)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .samples_data(samples_data),
        .samples_valid(samples_valid), .samples_ready(samples_ready), .bck(bck),
        .lrck(lrck), .sdata(sdata), .underflow(underflow), .underflow_count(underflow_count)
    );

    // Second instance starts its counter just below the limit to reach saturation quickly.
    i2s_transmitter #(.SAMPLE_BITS(SB), .SLOT_BITS(SLOT), .BCK_HALF(BH), .UFC_RESET(16'hFFFD)) u_sat (
        .clk(clk), .reset_n(reset_n), .enable(1'b1), .samples_data(48'h0),
        .samples_valid(1'b0), .samples_ready(sat_ready), .bck(sat_bck),
        .lrck(sat_lrck), .sdata(sat_sdata), .underflow(sat_underflow), .underflow_count(sat_count)
    );

    // Receiver model: sample on bck rise, restart the slot on each lrck change.
    logic          prev_bck = 1'b0;
    logic          prev_lrck = 1'b1;
    int            idx = 1000;
    logic [SB-1:0] word = '0;
    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            idx = 1000;
            prev_bck = 1'b0;
            prev_lrck = 1'b1;
        end else begin
            if (samples_ready) ready_cnt++;
            if (underflow) uf_cnt++;
            if (sat_underflow) sat_uf_cnt++;
            if (prev_bck && !bck) fall_cnt++;
            if (!prev_bck && bck) begin
                if (lrck != prev_lrck) idx = 0;
                else if (idx < 1000) idx++;
                if (idx >= 1 && idx <= SB) begin
                    word = {word[SB-2:0], sdata};
                    if (idx == SB) begin
                        if (lrck) dec_r.push_back(word);
                        else dec_l.push_back(word);
                    end
                end
                prev_lrck = lrck;
            end
            prev_bck = bck;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready(input int limit, output int waited);
        waited = 0;
        while (!samples_ready && waited < limit) begin
            step();
            waited++;
        end
    endtask

    // Hands n frames to the DUT (caller sets the first pair), then checks the decoded stream.
    task automatic run_frames(input int n, input bit valid_on, input string tag);
        int w;
        int last_cyc;
        last_cyc = 0;
        for (int f = 0; f < n; f++) begin
            samples_valid = valid_on;
            wait_ready(300, w);
            checks++;
            if (w >= 300) begin
                errors++;
                $display("FAIL %s ready_timeout frame=%0d waited=%0d required<300", tag, f, w);
            end
            if (f == 0) begin
                dec_l.delete();
                dec_r.delete();
                exp_q.delete();
            end else begin
                checks++;
                if (cyc - last_cyc !== FRAME_CLK) begin
                    errors++;
                    $display("FAIL %s ready_spacing got=%0d required=%0d", tag, cyc - last_cyc, FRAME_CLK);
                end
            end
            last_cyc = cyc;
            exp_q.push_back(valid_on ? samples_data : 48'h0);
            step();
            checks++;
            if (underflow !== !valid_on) begin
                errors++;
                $display("FAIL %s underflow_pulse got=%0b required=%0b", tag, underflow, !valid_on);
            end
            samples_data = {24'($urandom), 24'($urandom)};
        end
        repeat (240) step();
        checks++;
        if (dec_l.size() != exp_q.size() || dec_r.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s decode_count left=%0d right=%0d required=%0d", tag, dec_l.size(), dec_r.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (dec_l[i] !== exp_q[i][2*SB-1:SB] || dec_r[i] !== exp_q[i][SB-1:0]) begin
                    errors++;
                    $display("FAIL %s decode[%0d] got=%h/%h required=%h/%h", tag, i, dec_l[i], dec_r[i],
                             exp_q[i][2*SB-1:SB], exp_q[i][SB-1:0]);
                end
            end
        end
    endtask

    task automatic test_reset();
        int w;
        reset_n = 1'b0;
        enable = 1'b1;
        samples_valid = 1'b1;
        samples_data = {24'($urandom), 24'($urandom)};
        repeat (5) step();
        checks++;
        if ({bck, lrck, sdata, samples_ready, underflow} !== 5'b01000 || underflow_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_values got=%b cnt=%h required=01000 cnt=0000",
                     {bck, lrck, sdata, samples_ready, underflow}, underflow_count);
        end
        checks++;
        if (sat_count !== 16'hFFFD) begin
            errors++;
            $display("FAIL reset_sat_count got=%h required=FFFD", sat_count);
        end
        reset_n = 1'b1;
        wait_ready(50, w);
        checks++;
        if (w !== 2 * BH) begin
            errors++;
            $display("FAIL reset_first_boundary got=%0d required=%0d", w, 2 * BH);
        end
        step();
    endtask

    task automatic test_basic();
        int t1, t2, g;
        samples_data = {24'hABCDEF, 24'h123456};
        run_frames(1, 1'b1, "basic");
        t1 = 0; t2 = 0; g = 0;
        while (!(bck === 1'b0) && g < 20) begin step(); g++; end
        while (!(bck === 1'b1) && g < 20) begin step(); g++; end
        t1 = cyc;
        while (!(bck === 1'b0) && g < 20) begin step(); g++; end
        while (!(bck === 1'b1) && g < 20) begin step(); g++; end
        t2 = cyc;
        checks++;
        if (t2 - t1 !== 2 * BH) begin
            errors++;
            $display("FAIL basic_bck_period got=%0d required=%0d", t2 - t1, 2 * BH);
        end
    endtask

    task automatic test_back_to_back();
        int rc0;
        rc0 = ready_cnt;
        samples_data = {24'($urandom), 24'($urandom)};
        run_frames(4, 1'b1, "b2b");
        checks++;
        if (ready_cnt - rc0 !== 4) begin
            errors++;
            $display("FAIL b2b_ready_count got=%0d required=4", ready_cnt - rc0);
        end
    endtask

    task automatic test_underflow();
        int u0;
        u0 = uf_cnt;
        run_frames(3, 1'b0, "underflow");
        samples_valid = 1'b1;
        checks++;
        if (uf_cnt - u0 !== 3) begin
            errors++;
            $display("FAIL underflow_pulses got=%0d required=3", uf_cnt - u0);
        end
        checks++;
        if (underflow_count !== 16'd3) begin
            errors++;
            $display("FAIL underflow_count got=%0d required=3", underflow_count);
        end
    endtask

    task automatic test_enable_toggle();
        int w, t0, f0, rc0, u0, g;
        logic [15:0] c0;
        logic [2*SB-1:0] d;
        enable = 1'b1;
        samples_valid = 1'b1;
        d = {24'($urandom), 24'($urandom)};
        samples_data = d;
        wait_ready(300, w);
        t0 = cyc;
        dec_l.delete();
        dec_r.delete();
        f0 = fall_cnt;
        step();
        samples_data = {24'($urandom), 24'($urandom)};
        rc0 = ready_cnt; u0 = uf_cnt; c0 = underflow_count;
        g = 0;
        while (fall_cnt - f0 < 10 && g < 100) begin step(); g++; end
        enable = 1'b0;
        while (cyc - t0 < 500) step();
        checks++;
        if (ready_cnt !== rc0 || uf_cnt !== u0 || underflow_count !== c0) begin
            errors++;
            $display("FAIL toggle_no_ready ready=%0d uf=%0d cnt=%0d required=%0d/%0d/%0d",
                     ready_cnt - rc0, uf_cnt - u0, underflow_count, 0, 0, c0);
        end
        checks++;
        if (dec_l.size() != 2 || dec_r.size() != 2) begin
            errors++;
            $display("FAIL toggle_decode_count left=%0d right=%0d required=2", dec_l.size(), dec_r.size());
        end else begin
            checks++;
            if (dec_l[0] !== d[2*SB-1:SB] || dec_r[0] !== d[SB-1:0]) begin
                errors++;
                $display("FAIL toggle_current_frame got=%h/%h required=%h/%h", dec_l[0], dec_r[0],
                         d[2*SB-1:SB], d[SB-1:0]);
            end
            checks++;
            if (dec_l[1] !== 24'h0 || dec_r[1] !== 24'h0) begin
                errors++;
                $display("FAIL toggle_idle_frame got=%h/%h required=0/0", dec_l[1], dec_r[1]);
            end
        end
        enable = 1'b1;
    endtask

    task automatic test_midframe_reset();
        int w, f0, g;
        enable = 1'b1;
        samples_valid = 1'b1;
        wait_ready(300, w);
        f0 = fall_cnt;
        g = 0;
        while (fall_cnt - f0 < 40 && g < 400) begin step(); g++; end
        reset_n = 1'b0;
        step();
        checks++;
        if ({bck, lrck, sdata, samples_ready, underflow} !== 5'b01000 || underflow_count !== 16'h0) begin
            errors++;
            $display("FAIL midreset_values got=%b cnt=%h required=01000 cnt=0000",
                     {bck, lrck, sdata, samples_ready, underflow}, underflow_count);
        end
        reset_n = 1'b1;
        wait_ready(50, w);
        checks++;
        if (w !== 2 * BH) begin
            errors++;
            $display("FAIL midreset_first_boundary got=%0d required=%0d", w, 2 * BH);
        end
        step();
        checks++;
        if (sat_count !== 16'hFFFE || underflow_count !== 16'h0) begin
            errors++;
            $display("FAIL midreset_counts sat=%h main=%h required=FFFE/0000", sat_count, underflow_count);
        end
    endtask

    task automatic test_saturation();
        int s0, g;
        s0 = sat_uf_cnt;
        g = 0;
        while (sat_uf_cnt - s0 < 4 && g < 1500) begin step(); g++; end
        checks++;
        if (sat_uf_cnt - s0 < 4) begin
            errors++;
            $display("FAIL sat_pulses got=%0d required>=4", sat_uf_cnt - s0);
        end
        checks++;
        if (sat_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_count got=%h required=FFFF", sat_count);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        enable = 1'b0;
        samples_valid = 1'b0;
        samples_data = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_underflow();
        test_enable_toggle();
        test_midframe_reset();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
